// File: rtl/eic_ahb_slave.sv
// AHB-Lite responder bridging MIPSfpga+ bus transfers onto the EIC
// register access port: zero-wait word accesses, two-cycle ERROR otherwise.
module eic_ahb_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int REG_COUNT  = 13,
  parameter int ADDR_LSB   = 2
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]           read_data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic                  write_enable
);

  localparam int IW = ADDR_LSB + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] REG_LIM = (ADDR_WIDTH+1)'(REG_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] a_idx;
  logic                  accept;
  logic                  legal;
  logic                  open;
  logic                  unused_ok;

  assign a_idx  = HADDR[IW-1:ADDR_LSB];
  assign accept = HSEL & HREADY & HTRANS[1];
  assign legal  = (HSIZE == 3'b010)
               && (HADDR[ADDR_LSB-1:0] == '0)
               && ({1'b0, a_idx} < REG_LIM);
  // ERR1 stalls the bus and ERR2 sees only a cancelled address phase
  assign open   = (state == S_IDLE) || (state == S_RD) || (state == S_WR);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= S_IDLE;
      idx_q     <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      unique case (1'b1)
        (state == S_ERR1): begin
          state <= S_ERR2;
          HRESP <= 1'b1;
        end
        (open && accept && !legal): begin
          state     <= S_ERR1;
          HREADYOUT <= 1'b0;
          HRESP     <= 1'b1;
        end
        (open && accept && legal): begin
          state <= HWRITE ? S_WR : S_RD;
          idx_q <= a_idx;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign read_addr    = idx_q;
  assign HRDATA       = (state == S_RD) ? read_data : '0;
  assign write_addr   = idx_q;
  assign write_data   = HWDATA;
  assign write_enable = (state == S_WR);

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:IW], HTRANS[0]};

endmodule

// File: tb/tb_eic_ahb_slave.sv
// Bench for eic_ahb_slave: one-cycle-latency scoreboard of expected
// data-phase responses, with a small EIC register stub behind the port.
module tb_eic_ahb_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = T_IDLE;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [2:0]  HBURST = '0;
  logic [3:0]  HPROT = '0;
  logic        HMASTLOCK = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [3:0]  read_addr;
  logic [31:0] read_data;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;

  logic        hready_drv = 1'b1;
  logic        stub_load = 1'b1;
  logic [31:0] stub [16];

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
  } stim_t;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mdl [16];
  logic [31:0] wd_pend = '0;
  int          err_ph = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 CLK = ~CLK;

  assign HREADY    = hready_drv & HREADYOUT;
  assign read_data = stub[read_addr];

  always @(posedge CLK) begin
    if (stub_load) begin
      for (int i = 0; i < 16; i++)
        stub[i] <= 32'hA000_0000 + i;
    end else if (write_enable) begin
      stub[write_addr] <= write_data;
    end
  end

  eic_ahb_slave dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .HSEL         (HSEL),
    .HADDR        (HADDR),
    .HTRANS       (HTRANS),
    .HWRITE       (HWRITE),
    .HSIZE        (HSIZE),
    .HBURST       (HBURST),
    .HPROT        (HPROT),
    .HMASTLOCK    (HMASTLOCK),
    .HWDATA       (HWDATA),
    .HREADY       (HREADY),
    .HRDATA       (HRDATA),
    .HREADYOUT    (HREADYOUT),
    .HRESP        (HRESP),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable)
  );

  function automatic stim_t mk(input logic sel, input logic [1:0] tr,
                               input logic wr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic rdy);
    stim_t s;
    s.sel = sel; s.trans = tr; s.wr = wr; s.size = sz;
    s.addr = a; s.wdata = d; s.rdy = rdy;
    return s;
  endfunction

  function automatic stim_t fw(input logic [31:0] a, input logic [31:0] d);
    return mk(1'b1, T_NSEQ, 1'b1, 3'b010, a, d, 1'b1);
  endfunction

  function automatic stim_t fr(input logic [31:0] a);
    return mk(1'b1, T_NSEQ, 1'b0, 3'b010, a, 32'h0, 1'b1);
  endfunction

  function automatic stim_t fi();
    return mk(1'b0, T_IDLE, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.rdy = 1'b1; e.resp = 1'b0; e.we = 1'b0;
    e.waddr = '0; e.wdata = '0; e.rdata = '0;
    return e;
  endfunction

  // drive one address phase and predict the data phase that follows it
  task automatic issue(input stim_t s);
    exp_t       e;
    logic [3:0] ix;
    bit         ok;
    @(posedge CLK);
    #1;
    HSEL = s.sel; HTRANS = s.trans; HWRITE = s.wr;
    HSIZE = s.size; HADDR = s.addr; hready_drv = s.rdy;
    HWDATA = wd_pend;
    wd_pend = s.wdata;
    e = idle_exp();
    if (err_ph == 2) begin
      e.resp = 1'b1;
      err_ph = 1;
    end else if (err_ph == 1) begin
      err_ph = 0;
    end else if (s.sel && s.rdy && s.trans[1]) begin
      ix = s.addr[5:2];
      ok = (s.size == 3'b010) && (s.addr[1:0] == 2'b00) && (ix < 4'd13);
      if (!ok) begin
        e.rdy = 1'b0; e.resp = 1'b1; err_ph = 2;
      end else if (s.wr) begin
        e.we = 1'b1; e.waddr = ix; e.wdata = s.wdata;
        mdl[ix] = s.wdata;
      end else begin
        e.rdata = mdl[ix];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_chk++;
    if (HREADYOUT !== 1'b1) begin
      n_fail++; $display("FAIL reset HREADYOUT got %b want 1", HREADYOUT);
    end
    n_chk++;
    if (HRESP !== 1'b0) begin
      n_fail++; $display("FAIL reset HRESP got %b want 0", HRESP);
    end
    n_chk++;
    if (write_enable !== 1'b0) begin
      n_fail++; $display("FAIL reset write_enable got %b want 0", write_enable);
    end
    n_chk++;
    if (HRDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset HRDATA got %h want 0", HRDATA);
    end
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    stub_load = 1'b0;
    exp_q.push_back(idle_exp());
  endtask

  task automatic run_table(input string nm, input stim_t t [$]);
    exp_t e;
    for (int i = 0; i < t.size(); i++) begin
      issue(t[i]);
      @(negedge CLK);
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL %s[%0d] scoreboard empty", nm, i);
      end else begin
        e = exp_q.pop_front();
        n_chk++;
        if (HREADYOUT !== e.rdy) begin
          n_fail++;
          $display("FAIL %s[%0d] HREADYOUT got %b want %b", nm, i, HREADYOUT, e.rdy);
        end
        n_chk++;
        if (HRESP !== e.resp) begin
          n_fail++;
          $display("FAIL %s[%0d] HRESP got %b want %b", nm, i, HRESP, e.resp);
        end
        n_chk++;
        if (write_enable !== e.we) begin
          n_fail++;
          $display("FAIL %s[%0d] write_enable got %b want %b", nm, i, write_enable, e.we);
        end
        n_chk++;
        if (HRDATA !== e.rdata) begin
          n_fail++;
          $display("FAIL %s[%0d] HRDATA got %h want %h", nm, i, HRDATA, e.rdata);
        end
        if (e.we) begin
          n_chk++;
          if (write_addr !== e.waddr || write_data !== e.wdata) begin
            n_fail++;
            $display("FAIL %s[%0d] write got %0d/%h want %0d/%h",
                     nm, i, write_addr, write_data, e.waddr, e.wdata);
          end
        end
      end
    end
  endtask

  task automatic test_write_read();
    stim_t t [$];
    t = {fw(32'h04, 32'h0000_00F0), fr(32'h04), fi(), fr(32'h00), fi()};
    run_table("write_read", t);
  endtask

  task automatic test_back_to_back();
    stim_t t [$];
    t = {fw(32'h24, 32'h1111_2222), fw(32'h28, 32'h3333_4444),
         fr(32'h24), fr(32'h28), fi()};
    run_table("back_to_back", t);
  endtask

  task automatic test_errors();
    stim_t t [$];
    t = {mk(1'b1, T_NSEQ, 1'b1, 3'b000, 32'h04, 32'hBAD0_0001, 1'b1),
         fi(), fi(),
         fr(32'h34), fi(), fi(),
         fr(32'h06), fr(32'h30), fi(),
         fr(32'h30), fr(32'h04), fi()};
    run_table("errors", t);
  endtask

  task automatic test_non_transfers();
    stim_t t [$];
    t = {mk(1'b1, T_BUSY, 1'b0, 3'b010, 32'h04, 32'h0, 1'b1),
         mk(1'b0, T_NSEQ, 1'b1, 3'b010, 32'h08, 32'h5555_0000, 1'b1),
         mk(1'b1, T_NSEQ, 1'b1, 3'b010, 32'h08, 32'h6666_0000, 1'b0),
         fi(), fr(32'h08), fi()};
    run_table("non_transfers", t);
  endtask

  task automatic test_async_reset();
    logic [31:0] old;
    old = mdl[2];
    issue(fw(32'h08, 32'hDEAD_BEEF));
    exp_q.delete();
    @(posedge CLK);
    #2;
    HSEL = 1'b0; HTRANS = T_IDLE;
    n_chk++;
    if (write_enable !== 1'b1 || write_addr !== 4'd2) begin
      n_fail++;
      $display("FAIL async_pre strobe got %b/%0d want 1/2", write_enable, write_addr);
    end
    #1;
    RESETn = 1'b0;
    #1;
    n_chk++;
    if (write_enable !== 1'b0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      n_fail++;
      $display("FAIL async_drop we/rdy/resp got %b%b%b want 010",
               write_enable, HREADYOUT, HRESP);
    end
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (write_enable !== 1'b0) begin
      n_fail++; $display("FAIL async_post write_enable got %b want 0", write_enable);
    end
    n_chk++;
    if (stub[2] !== old) begin
      n_fail++; $display("FAIL async_dropped reg2 got %h want %h", stub[2], old);
    end
    mdl[2] = old;
    err_ph = 0;
    wd_pend = '0;
    exp_q.push_back(idle_exp());
    run_table("after_async", '{fr(32'h08), fi()});
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      mdl[i] = 32'hA000_0000 + i;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_non_transfers();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
